// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file (regfile_mp, regfile_scoreboard).
// Optional write-to-read forwarding in regfile_mp is enabled by REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    // Widest configuration the winner function has to cover.
    localparam int MAX_NWP   = 3;
    localparam int MAX_AW    = 8;
    localparam int MAX_WA_W  = MAX_NWP * MAX_AW;

    typedef struct packed {
        logic       hit;
        logic [1:0] port;
    } wr_win_t;

    // Highest-numbered enabled write port targeting addr; writes to the zero register never hit.
    function automatic wr_win_t wr_winner(
        input logic [MAX_NWP-1:0]  we,
        input logic [MAX_WA_W-1:0] wr_addr,
        input int                  aw,
        input logic [MAX_AW-1:0]   addr
    );
        wr_win_t           win;
        logic [MAX_AW-1:0] mask;
        logic [MAX_AW-1:0] a;
        win  = '0;
        mask = MAX_AW'((1 << aw) - 1);
        for (int w = 0; w < MAX_NWP; w++) begin
            a = MAX_AW'(wr_addr >> (w * aw)) & mask;
            if (we[w] && (a == addr) && (addr != MAX_AW'(ZERO_REG))) begin
                win.hit  = 1'b1;
                win.port = 2'(w);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: allocation sets, write-back clears, allocation wins a tie.
// Register 0 is never busy. Not affected by REGFILE_BYPASS_EN.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    parameter  int NWP   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWP-1:0]    we,
    input  logic [NWP*AW-1:0] wr_addr,
    input  logic              alloc_valid,
    input  logic [AW-1:0]     alloc_addr,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] w_vec;

    assign w_vec[ZERO_REG] = 1'b0;
    assign busy_vec        = w_vec;

    for (genvar r = 1; r < NREGS; r++) begin : g_bit
        logic r_b;
        logic w_set;
        logic w_clr;

        assign w_set = alloc_valid && (alloc_addr == AW'(r));

        always_comb begin
            w_clr = 1'b0;
            for (int w = 0; w < NWP; w++) begin
                if (we[w] && (wr_addr[w*AW +: AW] == AW'(r)))
                    w_clr = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                r_b <= 1'b0;
            else if (w_set)
                r_b <= 1'b1;
            else if (w_clr)
                r_b <= 1'b0;
        end

        assign w_vec[r] = r_b;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard; x0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRP   = 2,
    parameter  int NWP   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic [NWP-1:0]      we,
    input  logic [NWP*AW-1:0]   wr_addr,
    input  logic [NWP*XLEN-1:0] wr_data,
    input  logic                alloc_valid,
    input  logic [AW-1:0]       alloc_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [MAX_NWP-1:0]  w_we;
    logic [MAX_WA_W-1:0] w_wr_addr;
    logic [XLEN-1:0]     w_rf [NREGS];
    logic [NREGS-1:0]    w_busy;

    assign w_we           = MAX_NWP'(we);
    assign w_wr_addr      = MAX_WA_W'(wr_addr);
    assign w_rf[ZERO_REG] = '0;
    assign busy_vec       = w_busy;

    for (genvar r = 1; r < NREGS; r++) begin : g_reg
        logic [XLEN-1:0] r_q;
        wr_win_t         w_win;

        assign w_win = wr_winner(w_we, w_wr_addr, AW, MAX_AW'(r));

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                r_q <= '0;
            else if (w_win.hit)
                r_q <= wr_data[w_win.port*XLEN +: XLEN];
        end

        assign w_rf[r] = r_q;
    end

    regfile_scoreboard #(
        .NREGS(NREGS),
        .NWP  (NWP)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .wr_addr    (wr_addr),
        .alloc_valid(alloc_valid),
        .alloc_addr (alloc_addr),
        .busy_vec   (w_busy)
    );

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   w_a;
        logic [XLEN-1:0] w_data;
        logic            w_bsy;

        assign w_a = rd_addr[p*AW +: AW];

`ifdef REGFILE_BYPASS_EN
        wr_win_t w_fwd;
        logic    w_alloc_hit;

        // Reset masks forwarding so every output stays zero while reset is high.
        assign w_fwd       = wr_winner(w_we, w_wr_addr, AW, MAX_AW'(w_a));
        assign w_alloc_hit = alloc_valid && (alloc_addr == w_a);
        assign w_data      = (w_fwd.hit && !reset) ? wr_data[w_fwd.port*XLEN +: XLEN] : w_rf[w_a];
        assign w_bsy       = (w_fwd.hit && !reset) ? w_alloc_hit : w_busy[w_a];
`else
        assign w_data      = w_rf[w_a];
        assign w_bsy       = w_busy[w_a];
`endif

        assign rd_data[p*XLEN +: XLEN] = w_data;
        assign rd_busy[p]              = w_bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (NREGS=16, NRP=4, NWP=3, XLEN=64); follows REGFILE_BYPASS_EN when defined.
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 16;
    localparam int NRP   = 4;
    localparam int NWP   = 3;
    localparam int AW    = 4;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic [NWP-1:0]      we;
    logic [NWP*AW-1:0]   wr_addr;
    logic [NWP*XLEN-1:0] wr_data;
    logic                alloc_valid;
    logic [AW-1:0]       alloc_addr;
    logic [NREGS-1:0]    busy_vec;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    // Reference state: architectural register contents and busy set.
    logic [XLEN-1:0]  m_mem [NREGS];
    logic [NREGS-1:0] m_busy;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [NWP-1:0] we;
        logic [AW-1:0]  wa0, wa1, wa2;
        logic [XLEN-1:0] wd0, wd1, wd2;
        logic           av;
        logic [AW-1:0]  aa;
        logic [AW-1:0]  ra;
        logic [XLEN-1:0] ed;
        logic           eb;
    } vec_t;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
        m_busy = '0;
    endtask

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (reset || a == 0) return '0;
        if (BYP) begin
            for (int w = NWP-1; w >= 0; w--)
                if (we[w] && int'(wr_addr[w*AW +: AW]) == a) return wr_data[w*XLEN +: XLEN];
        end
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (reset || a == 0) return 1'b0;
        if (BYP) begin
            for (int w = 0; w < NWP; w++)
                if (we[w] && int'(wr_addr[w*AW +: AW]) == a)
                    return alloc_valid && int'(alloc_addr) == a;
        end
        return m_busy[a];
    endfunction

    task automatic check_outputs();
        int a;
        if (reset) model_clear();
        for (int p = 0; p < NRP; p++) begin
            a = int'(rd_addr[p*AW +: AW]);
            chk($sformatf("rd_data[%0d] x%0d", p, a), rd_data[p*XLEN +: XLEN], exp_data(a));
            chk($sformatf("rd_busy[%0d] x%0d", p, a), XLEN'(rd_busy[p]), XLEN'(exp_busy(a)));
        end
        chk("busy_vec", XLEN'(busy_vec), XLEN'(m_busy));
    endtask

    // Writes in port order so the last (highest) port naturally wins; alloc overrides clears.
    task automatic model_update();
        logic [NREGS-1:0] nb;
        int a;
        if (reset) return;
        nb = m_busy;
        for (int w = 0; w < NWP; w++) begin
            a = int'(wr_addr[w*AW +: AW]);
            if (we[w] && a != 0) begin
                m_mem[a] = wr_data[w*XLEN +: XLEN];
                nb[a]    = 1'b0;
            end
        end
        if (alloc_valid && alloc_addr != 0) nb[alloc_addr] = 1'b1;
        m_busy = nb;
    endtask

    task automatic idle();
        we = '0; wr_addr = '0; wr_data = '0;
        alloc_valid = 1'b0; alloc_addr = '0; rd_addr = '0;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1;
        idle();
        model_clear();

        // Rows: we, wa0..2, wd0..2, alloc_v, alloc_a, port-0 read addr, expected data, busy.
        tbl.push_back('{3'b000, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 64'h0, 1'b1, 4'd0, 4'd0, 64'h0, 1'b0});
        tbl.push_back('{3'b001, 4'd0, 4'd0, 4'd0, 64'h12345678, 64'h0, 64'h0, 1'b1, 4'd0, 4'd0, 64'h0, 1'b0});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 64'h0, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0});
        tbl.push_back('{3'b011, 4'd7, 4'd7, 4'd0, 64'h1, 64'h2, 64'h0, 1'b0, 4'd0, 4'd7, BYP ? 64'h2 : 64'h0, 1'b0});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 64'h0, 1'b0, 4'd0, 4'd7, 64'h2, 1'b0});
        tbl.push_back('{3'b111, 4'd7, 4'd8, 4'd7, 64'h10, 64'h20, 64'h30, 1'b0, 4'd0, 4'd7, BYP ? 64'h30 : 64'h2, 1'b0});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 64'h0, 1'b0, 4'd0, 4'd7, 64'h30, 1'b0});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 64'h0, 1'b0, 4'd0, 4'd8, 64'h20, 1'b0});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 64'h0, 1'b1, 4'd3, 4'd3, 64'h0, 1'b0});
        tbl.push_back('{3'b001, 4'd3, 4'd0, 4'd0, 64'hA5, 64'h0, 64'h0, 1'b1, 4'd3, 4'd3, BYP ? 64'hA5 : 64'h0, 1'b1});
        tbl.push_back('{3'b001, 4'd3, 4'd0, 4'd0, 64'hA5, 64'h0, 64'h0, 1'b0, 4'd0, 4'd3, 64'hA5, BYP ? 1'b0 : 1'b1});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 64'h0, 1'b0, 4'd0, 4'd3, 64'hA5, 1'b0});
        tbl.push_back('{3'b001, 4'd9, 4'd0, 4'd0, 64'h55, 64'h0, 64'h0, 1'b0, 4'd0, 4'd9, BYP ? 64'h55 : 64'h0, 1'b0});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 64'h0, 1'b0, 4'd0, 4'd9, 64'h55, 1'b0});
        tbl.push_back('{3'b000, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 64'h0, 1'b0, 4'd0, 4'd0, 64'h0, 1'b0});

        // Initial reset
        repeat (2) @(posedge clk);
        #1;
        rd_addr = {4'd3, 4'd9, 4'd7, 4'd5};
        @(negedge clk);
        chk("reset rd_data", rd_data[XLEN-1:0], 64'h0);
        chk("reset busy_vec", XLEN'(busy_vec), 64'h0);
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();

        // Write x5, read it back, then reset mid-write
        we = 3'b001; wr_addr = {4'd0, 4'd0, 4'd5}; wr_data[XLEN-1:0] = 64'hDEADBEEF;
        alloc_valid = 1'b1; alloc_addr = 4'd5; rd_addr = {4'd0, 4'd0, 4'd0, 4'd5};
        cycle();
        idle();
        rd_addr = {4'd0, 4'd0, 4'd0, 4'd5};
        @(negedge clk);
        chk("x5 after write", rd_data[XLEN-1:0], 64'hDEADBEEF);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
        we = 3'b001; wr_addr = {4'd0, 4'd0, 4'd5}; wr_data[XLEN-1:0] = 64'h1111;
        alloc_valid = 1'b1; alloc_addr = 4'd6;
        #2;
        reset = 1'b1;
        #1;
        chk("x5 under async reset", rd_data[XLEN-1:0], 64'h0);
        chk("busy_vec under async reset", XLEN'(busy_vec), 64'h0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        rd_addr = {4'd0, 4'd0, 4'd0, 4'd5};
        @(negedge clk);
        chk("x5 after reset release", rd_data[XLEN-1:0], 64'h0);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            we          = tbl[i].we;
            wr_addr     = {tbl[i].wa2, tbl[i].wa1, tbl[i].wa0};
            wr_data     = {tbl[i].wd2, tbl[i].wd1, tbl[i].wd0};
            alloc_valid = tbl[i].av;
            alloc_addr  = tbl[i].aa;
            rd_addr     = (NRP*AW)'($urandom);
            rd_addr[AW-1:0] = tbl[i].ra;
            @(negedge clk);
            chk($sformatf("tbl%0d data x%0d", i, tbl[i].ra), rd_data[XLEN-1:0], tbl[i].ed);
            chk($sformatf("tbl%0d busy x%0d", i, tbl[i].ra), XLEN'(rd_busy[0]), XLEN'(tbl[i].eb));
            chk($sformatf("tbl%0d busy_vec[0]", i), XLEN'(busy_vec[0]), 64'h0);
            check_outputs();
            @(posedge clk);
            model_update();
            #1;
        end

        // Random traffic; narrow address window half the time to force collisions
        for (int c = 0; c < 10000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            we    = NWP'($urandom);
            for (int w = 0; w < NWP; w++) begin
                wr_addr[w*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
                wr_data[w*XLEN +: XLEN] = {$urandom, $urandom};
            end
            alloc_valid = $urandom_range(0, 1) == 1;
            alloc_addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            for (int p = 0; p < NRP; p++)
                rd_addr[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard, the successor to the single-write, dual-read core register file. It sits in the decode/issue stage: issue reads operands and allocates destinations, and write-back ports (ALU, load) retire results. Register 0 is hardwired to zero. Optional same-cycle write-to-read forwarding is compiled in by macro.

## Interface
- XLEN, 32, data width in bits.
- NREGS, 32, register count; power of two, ≥ 4; AW = $clog2(NREGS).
- NRP, 2, read-port count (1–4).
- NWP, 2, write-port count (1–3).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NRP*AW  read addresses; port p is bits [p*AW +: AW].
- rd_data  out  NRP*XLEN  read data, port p at [p*XLEN +: XLEN].
- rd_busy  out  NRP  scoreboard bit of the register addressed by read port p.
- we  in  NWP  write enable per write port.
- wr_addr  in  NWP*AW  write addresses.
- wr_data  in  NWP*XLEN  write data.
- alloc_valid  in  1  issue has allocated a destination this cycle.
- alloc_addr  in  AW  destination being allocated.
- busy_vec  out  NREGS  full scoreboard; bit 0 is always 0.

## Operation
- Storage: NREGS-1 registers of XLEN bits (index 1..NREGS-1). Reads of address 0 return 0 with rd_busy = 0.
- Writes: on each edge, every port w with we[w]=1 and wr_addr ≠ 0 updates its register. Writes to address 0 are dropped.
- Write collision (two ports, same nonzero address, same cycle): the highest-numbered port wins. This is not an error.
- Scoreboard, per register r ≠ 0, next state:
  - Set if alloc_valid=1 and alloc_addr=r.
  - Otherwise cleared if any write port writes r.
  - Otherwise held.
  - Alloc and write-back to the same register in the same cycle therefore leave the bit set: the new producer owns the register.
- alloc_addr = 0 is ignored.
- A write to a register that is not busy is legal. The data is written and the bit stays 0.
- Reset (async, any time, including mid-write): every register is 0 and busy_vec is 0 while reset is high. The first write takes effect on the first rising edge after deassertion.

## Timing
- Reads are combinational, zero latency from rd_addr.
- Writes are visible on rd_data the cycle after the write edge (without bypass).
- A scoreboard set or clear is visible on busy_vec/rd_busy the cycle after the edge.
- Outputs under reset: rd_data = 0 for all ports, rd_busy = 0, busy_vec = 0.
- No backpressure. Every enabled write and every allocation is accepted.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If a read address matches an active write port this cycle (nonzero address), rd_data returns that port's wr_data. The highest-numbered matching port wins.
  - rd_busy returns 0 for that read, unless alloc_valid targets the same register in the same cycle.
  - This adds a combinational path from wr_data to rd_data.
- REGFILE_BYPASS_EN undefined: rd_data and rd_busy reflect state registered at the last edge only.

## Structure
- Shared package regfile_pkg holds:
  - XLEN_DEF = 32 and NREGS_DEF = 32.
  - ZERO_REG = 0.
  - A function returning the winning write port for a given address.
- One sub-module, regfile_scoreboard (params NREGS, NWP). It contains the busy-bit register array with async reset, set/clear priority, and the busy_vec output. regfile_mp instantiates it and owns the data array and the read muxes.

## Test plan
- Reset: assert reset mid-run after writing x5=0xDEADBEEF. rd_data for x5 reads 0 immediately and busy_vec=0. After deassertion, x5 reads 0 until it is rewritten.
- Zero register: write port 0 writes x0=0x12345678 and alloc_addr=0. x0 reads 0 and busy_vec[0]=0 on every subsequent cycle.
- Collision: port 0 writes x7=0x1 and port 1 writes x7=0x2 in the same cycle. Next cycle x7 reads 0x2.
- Scoreboard:
  - Alloc x3. Next cycle rd_busy=1 for x3.
  - Write-back x3=0xA5 while alloc x3 in the same cycle. Bit stays 1.
  - Write x3 again with no alloc. Next cycle bit is 0 and data is 0xA5 from the last write.
- Bypass (REGFILE_BYPASS_EN): write x9=0x55 while reading x9. rd_data=0x55 in the same cycle. Without the macro, the same cycle reads the old value (0) and the next cycle reads 0x55.
- Parameters: NREGS=16, NRP=4, NWP=3, XLEN=64. Random writes and reads against a reference model for 10k cycles show zero mismatches.
